// File: rtl/m68k_arb_pkg.sv
// Shared definitions for the 68000 DMA bus arbiter: FSM states, default
// timing constants and the width of the holdoff/tenure counters.
package m68k_arb_pkg;

  localparam int CNT_W              = 10;
  localparam int DEF_MIN_CPU_CYCLES = 4;
  localparam int DEF_MAX_TENURE     = 1023;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_GRANT     = 3'd3,
    ST_RELEASE   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/m68k_arb_counter.sv
// Loadable down-counter that stops at zero and flags when it is there.
// Used as the CPU holdoff timer and, with the watchdog, as the tenure timer.
module m68k_arb_counter
  import m68k_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus arbiter for a single DMA master. Requests the bus with BR_L,
// waits for the CPU grant and an idle bus, takes ownership with BGACK_L,
// then gives the CPU a guaranteed holdoff window after each DMA tenure.
// Optional tenure watchdog: define ARB_WATCHDOG_EN to bound a DMA tenure
// to MAX_TENURE GRANT cycles, pulsing Timeout_H on a forced release.
module m68k_bus_arbiter
  import m68k_arb_pkg::*;
#(
  parameter int MIN_CPU_CYCLES = DEF_MIN_CPU_CYCLES,
  parameter int MAX_TENURE     = DEF_MAX_TENURE
) (
  input  logic Clk,
  input  logic Reset_L,
  input  logic DMA_BR_L,
  input  logic CPU_BG_L,
  input  logic AS_L,
  input  logic Dtack_L,
  output logic BR_L,
  output logic BGACK_L,
  output logic CPU_DMA_Select,
  output logic DMA_Grant_H,
  output logic Timeout_H
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_CPU_CYCLES);

  arb_state_e state_q;
  logic       br_l_q;
  logic       bgack_l_q;
  logic       sel_q;
  logic       grant_q;

  logic       hold_zero;
  logic       hold_load;
  logic       rearm;
  logic       go_grant;
  logic       wd_fire;

  // Bus is free for DMA once the CPU has finished its current cycle.
  assign go_grant  = (state_q == ST_WAIT_IDLE) && !DMA_BR_L && AS_L && Dtack_L;
  assign hold_load = (state_q == ST_RELEASE);

  m68k_arb_counter #(.W(CNT_W)) u_holdoff (
    .clk_i      (Clk),
    .rst_n_i    (Reset_L),
    .load_i     (hold_load),
    .load_val_i (HOLD_LOAD),
    .dec_i      (1'b1),
    .zero_o     (hold_zero)
  );

`ifdef ARB_WATCHDOG_EN
  // Loaded with MAX_TENURE-1 so the zero flag is seen during the last
  // allowed GRANT cycle and the release lands after exactly MAX_TENURE cycles.
  localparam logic [CNT_W-1:0] TENURE_LOAD =
    (MAX_TENURE >= 1) ? CNT_W'(MAX_TENURE - 1) : '0;

  logic ten_zero;
  logic timeout_q;
  logic rearm_q;

  m68k_arb_counter #(.W(CNT_W)) u_tenure (
    .clk_i      (Clk),
    .rst_n_i    (Reset_L),
    .load_i     (go_grant),
    .load_val_i (TENURE_LOAD),
    .dec_i      (state_q == ST_GRANT),
    .zero_o     (ten_zero)
  );

  assign wd_fire   = (state_q == ST_GRANT) && !DMA_BR_L && ten_zero;
  assign rearm     = rearm_q;
  assign Timeout_H = timeout_q;

  // Watchdog pulse and re-arm: a forced release blocks new requests until
  // the DMA master is seen to drop its request.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      timeout_q <= 1'b0;
      rearm_q   <= 1'b1;
    end else begin
      timeout_q <= wd_fire;
      if (wd_fire) begin
        rearm_q <= 1'b0;
      end else if (DMA_BR_L) begin
        rearm_q <= 1'b1;
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_max_tenure;

  assign unused_max_tenure = CNT_W'(MAX_TENURE);
  assign wd_fire           = 1'b0;
  assign rearm             = 1'b1;
  assign Timeout_H         = 1'b0;
`endif

  // Arbitration FSM with registered bus-control outputs.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= ST_IDLE;
      br_l_q    <= 1'b1;
      bgack_l_q <= 1'b1;
      sel_q     <= 1'b1;
      grant_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!DMA_BR_L && hold_zero && rearm) begin
            state_q <= ST_REQ;
            br_l_q  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (DMA_BR_L) begin
            state_q <= ST_IDLE;
            br_l_q  <= 1'b1;
          end else if (!CPU_BG_L) begin
            state_q <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (DMA_BR_L) begin
            state_q <= ST_IDLE;
            br_l_q  <= 1'b1;
          end else if (go_grant) begin
            state_q   <= ST_GRANT;
            br_l_q    <= 1'b1;
            bgack_l_q <= 1'b0;
            sel_q     <= 1'b0;
            grant_q   <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (DMA_BR_L || wd_fire) begin
            state_q   <= ST_RELEASE;
            bgack_l_q <= 1'b1;
            grant_q   <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // Mux stays on DMA one extra cycle as bus turnaround.
          state_q <= ST_IDLE;
          sel_q   <= 1'b1;
        end
        default: begin
          state_q   <= ST_IDLE;
          br_l_q    <= 1'b1;
          bgack_l_q <= 1'b1;
          sel_q     <= 1'b1;
          grant_q   <= 1'b0;
        end
      endcase
    end
  end

  assign BR_L           = br_l_q;
  assign BGACK_L        = bgack_l_q;
  assign CPU_DMA_Select = sel_q;
  assign DMA_Grant_H    = grant_q;

endmodule
